// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus W-path splitter.
// Holds the FSM encoding and byte-lane geometry helpers.
package hyperbus_pkg;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    WaitBeat = 2'd1,
    Emit     = 2'd2
  } hyperbus_w2phy_state_t;

  localparam int MaxNab = 128;

  function automatic int phy_bytes(input int np);
    return 2 * np;
  endfunction

  function automatic int words_per_beat(
    input int sz,
    input int npb
  );
    return (1 << sz) / npb;
  endfunction

  function automatic logic [MaxNab-1:0] lane_mask(
    input int addr,
    input int sz,
    input int nab
  );
    int b;
    int lane;
    logic [MaxNab-1:0] m;
    b    = 1 << sz;
    lane = ((addr >> sz) << sz) % nab;
    m    = '0;
    for (int k = 0; k < MaxNab; k++) begin
      m[k] = (k >= lane) && (k < lane + b) && (k < nab);
    end
    return m;
  endfunction

endpackage

// File: rtl/hyperbus_w2phy.sv
// AXI W beat to PHY word splitter/packer.
// Wide beats split into slices, narrow beats packed.
module hyperbus_w2phy
  import hyperbus_pkg::*;
#(
  parameter int AxiDataWidth = 64,
  parameter int NumPhys      = 1,
  parameter int BurstLength  = 8,
  parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2:0]                size,
  input  logic                      is_a_write,
  input  logic                      trans_handshake,
  input  logic [AddrWidth-1:0]      start_addr,
  input  logic [BurstLength-1:0]    burst_len,
  input  logic                      axi_valid_i,
  output logic                      axi_ready_o,
  input  logic [AxiDataWidth-1:0]   axi_data_i,
  input  logic [AxiDataWidth/8-1:0] axi_strb_i,
  input  logic                      axi_last_i,
  output logic                      phy_valid_o,
  input  logic                      phy_ready_i,
  output logic [16*NumPhys-1:0]     data_o,
  output logic [2*NumPhys-1:0]      strb_o,
  output logic                      last_o,
  output logic                      mismatch_o
);

  localparam int NAB  = AxiDataWidth / 8;
  localparam int NPB  = phy_bytes(NumPhys);
  localparam int PW   = 16 * NumPhys;
  localparam int NpbW = $clog2(NPB);
  localparam int SubW = $clog2(NAB / NPB) + 1;
  localparam logic [2:0] NpbLog = 3'(NpbW);

  hyperbus_w2phy_state_t r_state, w_state_n;

  logic [2:0]              r_size;
  logic [BurstLength-1:0]  r_addr, r_left;
  logic [BurstLength-1:0]  w_aligned, w_next_addr;
  logic [AxiDataWidth-1:0] r_beat, w_mdata, w_sh_data;
  logic [NAB-1:0]          r_bmask, w_lmask, w_en, w_sh_mask;
  logic [PW-1:0]           r_pack, w_pk_data;
  logic [NPB-1:0]          r_pmask, w_pk_mask;
  logic [AddrWidth-1:0]    w_lane;
  logic [NpbW-1:0]         w_off;
  logic [SubW-1:0]         r_sub;
  logic                    r_wide, r_lastbeat, r_mismatch;
  logic                    w_fire, w_is_last, w_wide, w_pack_full;

  assign mismatch_o = r_mismatch;

  // Byte-lane geometry and the inline packer for the current beat
  always_comb begin
    w_aligned   = (r_addr >> r_size) << r_size;
    w_next_addr = w_aligned + (BurstLength'(1) << r_size);
    w_lane      = w_aligned[AddrWidth-1:0];
    w_off       = w_aligned[NpbW-1:0];
    w_lmask     = NAB'(lane_mask(32'(r_addr), 32'(r_size), NAB));
    w_en        = w_lmask & axi_strb_i;
    w_mdata     = '0;
    for (int k = 0; k < NAB; k++) begin
      w_mdata[8*k +: 8] = w_en[k] ? axi_data_i[8*k +: 8] : 8'h00;
    end
    w_sh_data   = w_mdata >> {w_lane, 3'b000};
    w_sh_mask   = w_en >> w_lane;
    w_pk_data   = w_sh_data[PW-1:0] << {w_off, 3'b000};
    w_pk_mask   = w_sh_mask[NPB-1:0] << w_off;
    w_is_last   = (r_left == '0);
    w_wide      = (r_size >= NpbLog);
    w_pack_full = (w_next_addr[NpbW-1:0] == '0) || w_is_last;
    w_fire      = (r_state == WaitBeat) && axi_valid_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= Idle;
    else       r_state <= w_state_n;
  end

  // Next state and state-decoded handshake/word outputs
  always_comb begin
    w_state_n   = r_state;
    axi_ready_o = 1'b0;
    phy_valid_o = 1'b0;
    data_o      = '0;
    strb_o      = '0;
    last_o      = 1'b0;
    unique case (r_state)
      Idle: begin
        if (trans_handshake && is_a_write) w_state_n = WaitBeat;
      end
      WaitBeat: begin
        axi_ready_o = 1'b1;
        if (axi_valid_i && (w_wide || w_pack_full)) w_state_n = Emit;
      end
      Emit: begin
        phy_valid_o = 1'b1;
        data_o      = r_wide ? r_beat[PW-1:0] : r_pack;
        strb_o      = r_wide ? r_bmask[NPB-1:0] : r_pmask;
        last_o      = r_lastbeat && (r_sub == '0);
        if (phy_ready_i && (r_sub == '0)) begin
          w_state_n = r_lastbeat ? Idle : WaitBeat;
        end
      end
      default: w_state_n = Idle;
    endcase
  end

  // Burst geometry, beat slicer and pack buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_size     <= '0;
      r_addr     <= '0;
      r_left     <= '0;
      r_beat     <= '0;
      r_bmask    <= '0;
      r_pack     <= '0;
      r_pmask    <= '0;
      r_sub      <= '0;
      r_wide     <= 1'b0;
      r_lastbeat <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if ((r_state == Idle) && trans_handshake && is_a_write) begin
        r_size  <= size;
        r_addr  <= BurstLength'(start_addr);
        r_left  <= burst_len;
        r_pack  <= '0;
        r_pmask <= '0;
      end
      if (w_fire) begin
        r_mismatch <= (axi_last_i != w_is_last);
        r_addr     <= w_next_addr;
        r_left     <= r_left - BurstLength'(1);
        r_lastbeat <= w_is_last;
        r_wide     <= w_wide;
        if (w_wide) begin
          r_beat  <= w_sh_data;
          r_bmask <= w_sh_mask;
          r_sub   <= SubW'(words_per_beat(32'(r_size), NPB) - 1);
        end else begin
          r_pack  <= r_pack | w_pk_data;
          r_pmask <= r_pmask | w_pk_mask;
          r_sub   <= '0;
        end
      end
      if ((r_state == Emit) && phy_ready_i) begin
        if (r_sub != '0) begin
          r_sub   <= r_sub - SubW'(1);
          r_beat  <= r_beat >> PW;
          r_bmask <= r_bmask >> NPB;
        end else begin
          r_pack  <= '0;
          r_pmask <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_w2phy.sv
// Self-checking bench for hyperbus_w2phy.
// Expected PHY words come from a byte-level burst model.
module tb_hyperbus_w2phy;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
    logic        l;
  } word_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [2:0]  size = '0;
  logic        is_a_write = 1'b0;
  logic        trans_handshake = 1'b0;
  logic [2:0]  start_addr = '0;
  logic [7:0]  burst_len = '0;
  logic        axi_valid_i = 1'b0;
  logic        axi_ready_o;
  logic [63:0] axi_data_i = '0;
  logic [7:0]  axi_strb_i = '0;
  logic        axi_last_i = 1'b0;
  logic        phy_valid_o;
  logic        phy_ready_i = 1'b1;
  logic [15:0] data_o;
  logic [1:0]  strb_o;
  logic        last_o;
  logic        mismatch_o;

  int    errors = 0;
  int    checks = 0;
  int    mism_cnt = 0;
  int    exp_mism = 0;
  bit    rdy_rand = 1'b0;
  bit    rdy_hold = 1'b1;

  word_t       expq[$];
  word_t       gotq[$];
  logic [63:0] bdata[$];
  logic [7:0]  bstrb[$];
  bit          blast[$];

  hyperbus_w2phy #(
    .AxiDataWidth(64),
    .NumPhys(1),
    .BurstLength(8),
    .AddrWidth(3)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .size(size),
    .is_a_write(is_a_write),
    .trans_handshake(trans_handshake),
    .start_addr(start_addr),
    .burst_len(burst_len),
    .axi_valid_i(axi_valid_i),
    .axi_ready_o(axi_ready_o),
    .axi_data_i(axi_data_i),
    .axi_strb_i(axi_strb_i),
    .axi_last_i(axi_last_i),
    .phy_valid_o(phy_valid_o),
    .phy_ready_i(phy_ready_i),
    .data_o(data_o),
    .strb_o(strb_o),
    .last_o(last_o),
    .mismatch_o(mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    phy_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
  end

  always @(negedge clk_i) begin
    if (phy_valid_o && phy_ready_i)
      gotq.push_back(word_t'({data_o, strb_o, last_o}));
    if (mismatch_o) mism_cnt++;
  end

  task automatic fill_random(input int len, input bit full);
    bdata.delete(); bstrb.delete(); blast.delete();
    for (int i = 0; i <= len; i++) begin
      bdata.push_back({$urandom, $urandom});
      bstrb.push_back(full ? 8'hFF : 8'($urandom));
      blast.push_back(i == len);
    end
  endtask

  task automatic build_exp(input int sz, input int addr, input int len);
    int a, b, al, lane, off, k;
    logic [15:0] pd;
    logic [1:0]  pm;
    logic [63:0] bd;
    logic [7:0]  bs;
    word_t x;
    bit last;
    expq.delete();
    exp_mism = 0;
    a = addr; b = 1 << sz; pd = '0; pm = '0;
    for (int i = 0; i <= len; i++) begin
      bd = bdata[i]; bs = bstrb[i];
      al = (a / b) * b;
      lane = al % 8;
      last = (i == len);
      if (blast[i] != last) exp_mism++;
      if (b >= 2) begin
        for (int w = 0; w < b / 2; w++) begin
          x = '0;
          for (int j = 0; j < 2; j++) begin
            k = lane + 2 * w + j;
            if (bs[k]) begin
              x.d[8*j +: 8] = bd[8*k +: 8];
              x.s[j] = 1'b1;
            end
          end
          x.l = last && (w == b / 2 - 1);
          expq.push_back(x);
        end
      end else begin
        off = al % 2;
        if (bs[lane]) begin
          pd[8*off +: 8] = bd[8*lane +: 8];
          pm[off] = 1'b1;
        end
        if (((al + b) % 2 == 0) || last) begin
          x.d = pd; x.s = pm; x.l = last;
          expq.push_back(x);
          pd = '0; pm = '0;
        end
      end
      a = (al + b) % 256;
    end
  endtask

  task automatic start_burst(input int sz, input int addr, input int len);
    trans_handshake = 1'b1;
    is_a_write = 1'b1;
    size = 3'(sz);
    start_addr = 3'(addr);
    burst_len = 8'(len);
    @(posedge clk_i); #1;
    trans_handshake = 1'b0;
    is_a_write = 1'b0;
  endtask

  task automatic send_beats(output bit ok);
    int t;
    bit acc;
    ok = 1'b1;
    for (int i = 0; i < bdata.size(); i++) begin
      if (rdy_rand)
        repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
      axi_valid_i = 1'b1;
      axi_data_i = bdata[i];
      axi_strb_i = bstrb[i];
      axi_last_i = blast[i];
      acc = 1'b0; t = 0;
      while (!acc && t < 100) begin
        @(negedge clk_i); acc = axi_ready_o;
        @(posedge clk_i); #1; t++;
      end
      if (!acc) ok = 1'b0;
      axi_valid_i = 1'b0;
    end
    axi_last_i = 1'b0;
  endtask

  task automatic wait_words(output bit ok);
    int t = 0;
    while (gotq.size() < expq.size() && t < 400) begin
      @(posedge clk_i); #1; t++;
    end
    ok = (gotq.size() >= expq.size());
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic run_burst(input int sz, input int addr, input int len, output bit ok);
    bit ok1, ok2;
    build_exp(sz, addr, len);
    gotq.delete();
    mism_cnt = 0;
    start_burst(sz, addr, len);
    send_beats(ok1);
    wait_words(ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    axi_valid_i = 1'b1; trans_handshake = 1'b1; is_a_write = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    axi_valid_i = 1'b0; trans_handshake = 1'b0; is_a_write = 1'b0;
    @(negedge clk_i);
    checks++; if (phy_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", phy_valid_o); end
    checks++; if (axi_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b need 0", axi_ready_o); end
    checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL rst_data: got %h need 0", data_o); end
    checks++; if (strb_o !== 2'b0) begin errors++; $display("FAIL rst_strb: got %b need 0", strb_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL rst_last: got %b need 0", last_o); end
    checks++; if (mismatch_o !== 1'b0) begin errors++; $display("FAIL rst_mism: got %b need 0", mismatch_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_wide();
    bit ok;
    fill_random(1, 1'b1);
    run_burst(3, 0, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wide_timeout: got %0d words need %0d", gotq.size(), expq.size()); end
    checks++; if (gotq.size() != 8) begin errors++; $display("FAIL wide_count: got %0d need 8", gotq.size()); end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= gotq.size() || gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL wide_word%0d: got %h need %h", i, gotq[i], expq[i]);
      end
    end
    checks++; if (mism_cnt != 0) begin errors++; $display("FAIL wide_mism: got %0d need 0", mism_cnt); end
  endtask

  task automatic test_narrow();
    bit ok;
    logic [7:0] nv [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    word_t ne [2];
    ne[0] = word_t'({16'hBBAA, 2'b11, 1'b0});
    ne[1] = word_t'({16'hDDCC, 2'b11, 1'b1});
    bdata.delete(); bstrb.delete(); blast.delete();
    for (int i = 0; i < 4; i++) begin
      bdata.push_back(64'(nv[i]) << (8 * i));
      bstrb.push_back(8'(1 << i));
      blast.push_back(i == 3);
    end
    run_burst(0, 0, 3, ok);
    checks++; if (!ok || gotq.size() != 2) begin errors++; $display("FAIL narrow_count: got %0d need 2", gotq.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= gotq.size() || gotq[i] !== ne[i]) begin
        errors++;
        $display("FAIL narrow_word%0d: got %h need %h", i, gotq[i], ne[i]);
      end
    end
  endtask

  task automatic test_unaligned();
    bit ok;
    word_t ue;
    ue = word_t'({16'h5A00, 2'b10, 1'b1});
    bdata.delete(); bstrb.delete(); blast.delete();
    bdata.push_back(64'h5A << 40);
    bstrb.push_back(8'h20);
    blast.push_back(1'b1);
    run_burst(0, 5, 0, ok);
    checks++; if (!ok || gotq.size() != 1) begin errors++; $display("FAIL unal_count: got %0d need 1", gotq.size()); end
    checks++;
    if (gotq.size() < 1 || gotq[0] !== ue) begin
      errors++;
      $display("FAIL unal_word: got %h need %h", gotq[0], ue);
    end
  endtask

  task automatic test_backpressure();
    int n, t;
    bit ok;
    fill_random(0, 1'b1);
    build_exp(3, 0, 0);
    gotq.delete(); mism_cnt = 0; rdy_hold = 1'b1;
    start_burst(3, 0, 0);
    send_beats(ok);
    n = 0; t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk_i);
      if (phy_valid_o && phy_ready_i) n++;
      t++;
    end
    rdy_hold = 1'b0;
    checks++; if (!ok || n < 2) begin errors++; $display("FAIL bp_start: got %0d words need 2", n); end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if ({phy_valid_o, axi_ready_o, data_o, strb_o} !== {1'b1, 1'b0, expq[2].d, expq[2].s}) begin
        errors++;
        $display("FAIL bp_hold: got v=%b r=%b d=%h s=%b need v=1 r=0 d=%h s=%b",
                 phy_valid_o, axi_ready_o, data_o, strb_o, expq[2].d, expq[2].s);
      end
    end
    rdy_hold = 1'b1;
    wait_words(ok);
    checks++; if (!ok || gotq.size() != 4) begin errors++; $display("FAIL bp_count: got %0d need 4", gotq.size()); end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= gotq.size() || gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL bp_word%0d: got %h need %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_early_last();
    bit ok;
    fill_random(1, 1'b1);
    blast[0] = 1'b1;
    run_burst(3, 0, 1, ok);
    checks++; if (!ok || gotq.size() != 8) begin errors++; $display("FAIL early_count: got %0d need 8", gotq.size()); end
    checks++; if (mism_cnt != exp_mism) begin errors++; $display("FAIL early_mism: got %0d need %0d", mism_cnt, exp_mism); end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= gotq.size() || gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL early_word%0d: got %h need %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    fill_random(0, 1'b1);
    build_exp(3, 0, 0);
    gotq.delete(); rdy_hold = 1'b1;
    start_burst(3, 0, 0);
    send_beats(ok);
    t = 0;
    while (gotq.size() < 1 && t < 50) begin @(posedge clk_i); #1; t++; end
    checks++; if (!ok || gotq.size() < 1) begin errors++; $display("FAIL rmid_start: got %0d words need 1", gotq.size()); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if ({phy_valid_o, axi_ready_o, data_o, strb_o, last_o, mismatch_o} !== 22'h0) begin
        errors++;
        $display("FAIL rmid_idle: got v=%b r=%b d=%h s=%b l=%b m=%b need all 0",
                 phy_valid_o, axi_ready_o, data_o, strb_o, last_o, mismatch_o);
      end
    end
    @(posedge clk_i); #1;
    fill_random(1, 1'b0);
    run_burst(2, 4, 1, ok);
    checks++; if (!ok || gotq.size() != expq.size()) begin errors++; $display("FAIL rmid_count: got %0d need %0d", gotq.size(), expq.size()); end
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (i >= gotq.size() || gotq[i] !== expq[i]) begin
        errors++;
        $display("FAIL rmid_word%0d: got %h need %h", i, gotq[i], expq[i]);
      end
    end
  endtask

  task automatic test_random();
    int sz, addr, len;
    bit ok;
    rdy_rand = 1'b1;
    for (int n = 0; n < 12; n++) begin
      sz = $urandom_range(0, 3);
      addr = $urandom_range(0, 7);
      len = $urandom_range(0, 6);
      fill_random(len, $urandom_range(0, 3) == 0);
      run_burst(sz, addr, len, ok);
      checks++;
      if (!ok || gotq.size() != expq.size()) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d need %0d", n, gotq.size(), expq.size());
      end
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (i >= gotq.size() || gotq[i] !== expq[i]) begin
          errors++;
          $display("FAIL rnd%0d_word%0d: got %h need %h", n, i, gotq[i], expq[i]);
        end
      end
      checks++;
      if (mism_cnt != 0 || phy_valid_o !== 1'b0 || axi_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_end: got mism=%0d v=%b r=%b need 0 0 0", n, mism_cnt, phy_valid_o, axi_ready_o);
      end
    end
    rdy_rand = 1'b0;
    rdy_hold = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wide();
    test_narrow();
    test_unaligned();
    test_backpressure();
    test_early_last();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
